// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants and types for the hazard/forwarding scoreboard.
// Optional feature macro: HAZARD_WD_BYPASS_EN (D-stage bypass from W write data).
package hazard_scoreboard_pkg;

    localparam int FWD_REGFILE = 0;

    // How the writer shift register moves on the next edge.
    typedef enum logic [1:0] {
        ADV_NORMAL,
        ADV_BUBBLE,
        ADV_FLUSH,
        ADV_HOLD
    } adv_e;

endpackage

// File: rtl/hazard_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module hazard_scoreboard_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller: tracks in-flight writers S1(X)..S[NSTAGE](W) and produces
// stall, flush, dmem-wait freeze and registered X forward selects. Macro: HAZARD_WD_BYPASS_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREGS      = 32,
    parameter int ADDRW      = $clog2(NREGS),
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 2,
    parameter int FSW        = $clog2(NSTAGE + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [ADDRW-1:0] d_rs1,
    input  logic [ADDRW-1:0] d_rs2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic [ADDRW-1:0] d_rd,
    input  logic             d_wen,
    input  logic             d_is_load,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             hold_fd,
    output logic             bubble_x,
    output logic             hold_all,
    output logic             flush_fd,
    output logic [FSW-1:0]   fwd1_x,
    output logic [FSW-1:0]   fwd2_x,
    output logic             d_wd1,
    output logic             d_wd2,
    output logic [31:0]      stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic [ADDRW-1:0] rd;
        logic             wen;
        logic             is_load;
    } entry_t;

    entry_t         sb [1:NSTAGE];
    logic           use1, use2;
    logic [FSW-1:0] sel1, sel2;
    logic           young1, young2, ld1, ld2, tail1, tail2;
    logic           wd1, wd2, tail_hazard, hazard;
    logic           hold_all_i, flush_i, stall_i;
    adv_e           mode;

    always_comb begin
        use1   = d_valid & d_use1 & (d_rs1 != '0);
        use2   = d_valid & d_use2 & (d_rs2 != '0);
        sel1   = FSW'(FWD_REGFILE);
        sel2   = FSW'(FWD_REGFILE);
        young1 = 1'b0;
        young2 = 1'b0;
        ld1    = 1'b0;
        ld2    = 1'b0;
        // Walk oldest to youngest so the lowest matching stage wins.
        for (int k = NSTAGE - 1; k >= 1; k--) begin
            if (use1 && sb[k].valid && sb[k].wen && (sb[k].rd == d_rs1)) begin
                sel1   = FSW'(k + 1);
                young1 = 1'b1;
                ld1    = sb[k].is_load && ((k + 1) <= LOAD_STAGE);
            end
            if (use2 && sb[k].valid && sb[k].wen && (sb[k].rd == d_rs2)) begin
                sel2   = FSW'(k + 1);
                young2 = 1'b1;
                ld2    = sb[k].is_load && ((k + 1) <= LOAD_STAGE);
            end
        end
        tail1 = use1 & sb[NSTAGE].valid & sb[NSTAGE].wen & (sb[NSTAGE].rd == d_rs1) & ~young1;
        tail2 = use2 & sb[NSTAGE].valid & sb[NSTAGE].wen & (sb[NSTAGE].rd == d_rs2) & ~young2;
`ifdef HAZARD_WD_BYPASS_EN
        wd1         = tail1;
        wd2         = tail2;
        tail_hazard = 1'b0;
`else
        wd1         = 1'b0;
        wd2         = 1'b0;
        tail_hazard = tail1 | tail2;
`endif
        hazard     = ld1 | ld2 | tail_hazard;
        hold_all_i = mem_req & ~mem_ack;
        flush_i    = br_taken & ~hold_all_i;
        stall_i    = hazard & ~flush_i & ~hold_all_i;

        if (hold_all_i)   mode = ADV_HOLD;
        else if (flush_i) mode = ADV_FLUSH;
        else if (stall_i) mode = ADV_BUBBLE;
        else              mode = ADV_NORMAL;

        // Outputs are forced quiet while reset is asserted so no hold leaks out.
        hold_fd  = ~reset & (hold_all_i | stall_i);
        bubble_x = ~reset & stall_i;
        hold_all = ~reset & hold_all_i;
        flush_fd = ~reset & flush_i;
        d_wd1    = ~reset & wd1;
        d_wd2    = ~reset & wd2;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 1; k <= NSTAGE; k++) sb[k] <= '0;
            fwd1_x <= FSW'(FWD_REGFILE);
            fwd2_x <= FSW'(FWD_REGFILE);
        end else if (mode != ADV_HOLD) begin
            for (int k = 2; k <= NSTAGE; k++) sb[k] <= sb[k-1];
            if (mode == ADV_NORMAL) begin
                sb[1]  <= {d_valid, d_rd, d_wen, d_is_load};
                fwd1_x <= sel1;
                fwd2_x <= sel2;
            end else begin
                sb[1]  <= '0;
                fwd1_x <= FSW'(FWD_REGFILE);
                fwd2_x <= FSW'(FWD_REGFILE);
            end
        end
    end

    hazard_scoreboard_sat_counter #(
        .WIDTH(32)
    ) u_stall_cnt (
        .clock(clock),
        .clear(reset),
        .inc  (hold_fd),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (default parameters, NSTAGE=3, LOAD_STAGE=2).
module tb_hazard_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        d_valid, d_use1, d_use2, d_wen, d_is_load;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        br_taken, mem_req, mem_ack;
    logic        hold_fd, bubble_x, hold_all, flush_fd, d_wd1, d_wd2;
    logic [1:0]  fwd1_x, fwd2_x;
    logic [31:0] stall_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stall = 32'd0;

    always #5 clock = ~clock;

    hazard_scoreboard dut (
        .clock(clock), .reset(reset),
        .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_use1(d_use1), .d_use2(d_use2),
        .d_rd(d_rd), .d_wen(d_wen), .d_is_load(d_is_load),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .hold_fd(hold_fd), .bubble_x(bubble_x), .hold_all(hold_all), .flush_fd(flush_fd),
        .fwd1_x(fwd1_x), .fwd2_x(fwd2_x), .d_wd1(d_wd1), .d_wd2(d_wd2), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_d(input logic v, input logic [4:0] rs1, input logic u1,
                           input logic [4:0] rs2, input logic u2,
                           input logic [4:0] rd, input logic w, input logic ld);
        d_valid = v; d_rs1 = rs1; d_use1 = u1; d_rs2 = rs2; d_use2 = u2;
        d_rd = rd; d_wen = w; d_is_load = ld;
    endtask

    task automatic drain();
        drive_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_d(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1);
        br_taken = 1'b1; mem_req = 1'b0; mem_ack = 1'b0;
        tick(); tick();
        checks++; if (flush_fd !== 1'b0) begin errors++; $display("FAIL rst_flush_fd got %0b want 0", flush_fd); end
        checks++; if (hold_fd !== 1'b0) begin errors++; $display("FAIL rst_hold_fd got %0b want 0", hold_fd); end
        checks++; if ({fwd1_x, fwd2_x} !== 4'd0) begin errors++; $display("FAIL rst_fwd got %0d/%0d want 0/0", fwd1_x, fwd2_x); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d want 0", stall_cnt); end
        reset = 1'b0;
        drain();
    endtask

    task automatic test_forward();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // ADD x5
        tick();
        drive_d(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd9, 1'b1, 1'b0);   // SUB x9,x5,x6
        #1;
        checks++; if (hold_fd !== 1'b0) begin errors++; $display("FAIL fwd_hold_fd got %0b want 0", hold_fd); end
        tick();
        checks++; if (fwd1_x !== 2'd2) begin errors++; $display("FAIL fwd_m_fwd1 got %0d want 2", fwd1_x); end
        checks++; if (fwd2_x !== 2'd0) begin errors++; $display("FAIL fwd_m_fwd2 got %0d want 0", fwd2_x); end
        drain();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);  // writer x10
        tick();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);  // writer x11
        tick();
        drive_d(1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 5'd12, 1'b1, 1'b0);
        #1;
        checks++; if (hold_fd !== 1'b0) begin errors++; $display("FAIL fwd2_hold_fd got %0b want 0", hold_fd); end
        tick();
        checks++; if ({fwd1_x, fwd2_x} !== {2'd3, 2'd2}) begin errors++; $display("FAIL fwd_mw got %0d/%0d want 3/2", fwd1_x, fwd2_x); end
        drain();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // two writers of x5: youngest wins
        tick();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        drive_d(1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd14, 1'b1, 1'b0);
        tick();
        checks++; if (fwd2_x !== 2'd2) begin errors++; $display("FAIL fwd_youngest got %0d want 2", fwd2_x); end
        drain();
    endtask

    task automatic test_load_use();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);   // LW x6
        tick();
        drive_d(1'b1, 5'd6, 1'b1, 5'd1, 1'b1, 5'd7, 1'b1, 1'b0);   // ADD x7,x6,x1
        #1;
        checks++; if ({hold_fd, bubble_x} !== 2'b11) begin errors++; $display("FAIL lu_stall got %b want 11", {hold_fd, bubble_x}); end
        tick();
        exp_stall = exp_stall + 32'd1;
        checks++; if (fwd1_x !== 2'd0) begin errors++; $display("FAIL lu_bubble_fwd got %0d want 0", fwd1_x); end
        checks++; if ({hold_fd, bubble_x} !== 2'b00) begin errors++; $display("FAIL lu_release got %b want 00", {hold_fd, bubble_x}); end
        tick();
        checks++; if (fwd1_x !== 2'd3) begin errors++; $display("FAIL lu_fwd_w got %0d want 3", fwd1_x); end
        checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL lu_stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
        drain();
    endtask

    task automatic test_tail();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);   // writer x8
        tick();
        drive_d(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick(); tick();
        drive_d(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
        #1;
`ifdef HAZARD_WD_BYPASS_EN
        checks++; if ({d_wd1, hold_fd} !== 2'b10) begin errors++; $display("FAIL tail_bypass got wd1,hold=%b want 10", {d_wd1, hold_fd}); end
        tick();
`else
        checks++; if ({d_wd1, hold_fd, bubble_x} !== 3'b011) begin errors++; $display("FAIL tail_stall got wd1,hold,bub=%b want 011", {d_wd1, hold_fd, bubble_x}); end
        tick();
        exp_stall = exp_stall + 32'd1;
        checks++; if (hold_fd !== 1'b0) begin errors++; $display("FAIL tail_release got %0b want 0", hold_fd); end
`endif
        checks++; if (fwd1_x !== 2'd0) begin errors++; $display("FAIL tail_fwd got %0d want 0", fwd1_x); end
        checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL tail_stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
        drain();
    endtask

    task automatic test_mem_wait();
        int seen;
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);   // ADD x5
        tick();
        drive_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);   // SUB reads x5
        tick();
        drive_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);  // another x5 reader waits in D
        mem_req = 1'b1; mem_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (hold_all === 1'b1 && hold_fd === 1'b1 && bubble_x === 1'b0) seen++;
            tick();
            exp_stall = exp_stall + 32'd1;
            checks++; if (fwd1_x !== 2'd2) begin errors++; $display("FAIL mw_fwd_stable[%0d] got %0d want 2", i, fwd1_x); end
        end
        checks++; if (seen !== 4) begin errors++; $display("FAIL mw_hold_cycles got %0d want 4", seen); end
        mem_ack = 1'b1;
        #1;
        checks++; if ({hold_all, hold_fd} !== 2'b00) begin errors++; $display("FAIL mw_ack got hold_all,hold=%b want 00", {hold_all, hold_fd}); end
        tick();
        checks++; if (fwd1_x !== 2'd3) begin errors++; $display("FAIL mw_after_fwd got %0d want 3", fwd1_x); end
        checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL mw_stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
        drain();
    endtask

    task automatic test_flush();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);   // LW x6
        tick();
        drive_d(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);   // load-use ADD x7
        br_taken = 1'b1;
        #1;
        checks++; if ({flush_fd, bubble_x, hold_fd} !== 3'b100) begin errors++; $display("FAIL fl_outputs got flush,bub,hold=%b want 100", {flush_fd, bubble_x, hold_fd}); end
        tick();
        checks++; if (fwd1_x !== 2'd0) begin errors++; $display("FAIL fl_fwd got %0d want 0", fwd1_x); end
        br_taken = 1'b0;
        drive_d(1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 5'd13, 1'b1, 1'b0);
        #1;
        checks++; if (hold_fd !== 1'b0) begin errors++; $display("FAIL fl_next_hold got %0b want 0", hold_fd); end
        tick();
        checks++; if ({fwd1_x, fwd2_x} !== {2'd0, 2'd3}) begin errors++; $display("FAIL fl_s1_bubble got %0d/%0d want 0/3", fwd1_x, fwd2_x); end
        br_taken = 1'b1; mem_req = 1'b1; mem_ack = 1'b0;
        #1;
        checks++; if ({flush_fd, hold_all, hold_fd} !== 3'b011) begin errors++; $display("FAIL fl_wait got flush,hold_all,hold=%b want 011", {flush_fd, hold_all, hold_fd}); end
        tick();
        exp_stall = exp_stall + 32'd1;
        checks++; if (stall_cnt !== exp_stall) begin errors++; $display("FAIL fl_stall_cnt got %0d want %0d", stall_cnt, exp_stall); end
        drain();
    endtask

    task automatic test_x0();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);   // LW x0
        tick();
        drive_d(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        #1;
        checks++; if (hold_fd !== 1'b0) begin errors++; $display("FAIL x0_hold got %0b want 0", hold_fd); end
        tick();
        checks++; if ({fwd1_x, fwd2_x} !== 4'd0) begin errors++; $display("FAIL x0_fwd got %0d/%0d want 0/0", fwd1_x, fwd2_x); end
        drain();
    endtask

    task automatic test_reset_mid();
        drive_d(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        tick();
        drive_d(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        tick();
        mem_req = 1'b1; mem_ack = 1'b0;
        #1;
        checks++; if (hold_all !== 1'b1) begin errors++; $display("FAIL rm_wait got %0b want 1", hold_all); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if ({hold_all, hold_fd, bubble_x, flush_fd} !== 4'd0) begin errors++; $display("FAIL rm_ctrl got %b want 0000", {hold_all, hold_fd, bubble_x, flush_fd}); end
        checks++; if ({fwd1_x, fwd2_x} !== 4'd0) begin errors++; $display("FAIL rm_fwd got %0d/%0d want 0/0", fwd1_x, fwd2_x); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rm_stall_cnt got %0d want 0", stall_cnt); end
        reset = 1'b0; mem_req = 1'b0;
        drive_d(1'b1, 5'd9, 1'b1, 5'd5, 1'b1, 5'd16, 1'b1, 1'b0);
        #1;
        checks++; if (hold_fd !== 1'b0) begin errors++; $display("FAIL rm_residual got %0b want 0", hold_fd); end
        tick();
        checks++; if ({fwd1_x, fwd2_x} !== 4'd0) begin errors++; $display("FAIL rm_after_fwd got %0d/%0d want 0/0", fwd1_x, fwd2_x); end
        drain();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_tail();
        test_mem_wait();
        test_flush();
        test_x0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
